car_detector: RTL and testbench

Upstream conditioning stage for the traffic-light controller: it takes the raw, asynchronous, bouncy road-loop sensor on the country road and produces the clean `car` request consumed by the highway/country-road FSM pair. It synchronizes the sensor, debounces it, and latches each detected vehicle as a request that is held until the country road is served green. It also keeps a saturating vehicle count and flags a stuck sensor so a failed loop cannot lock the highway red.

---
 rtl/car_detector_pkg.sv | 16 +
 rtl/sync_2ff.sv | 24 ++
 rtl/car_detector.sv | 152 +++++++++++++++
 tb/tb_car_detector.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/car_detector_pkg.sv
// rtl/car_detector_pkg.sv - shared types and default constants for the country-road car detector
package car_detector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMING    = 3'd1,
    ST_PRESENT   = 3'd2,
    ST_RELEASING = 3'd3,
    ST_STUCK     = 3'd4
  } det_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_STUCK_CYCLES    = 1024;
  localparam int unsigned DEF_CNT_W           = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic 1-bit two-flop synchronizer, async active-low reset
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/car_detector.sv
// rtl/car_detector.sv - synchronizes and debounces the road-loop sensor into a held car request,
// with a saturating vehicle count and stuck-sensor detection
module car_detector
  import car_detector_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor_raw,
  input  logic             light_n_g,
  output logic             car,
  output logic [CNT_W-1:0] car_count,
  output logic             fault
);

  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned STK_W = $clog2(STUCK_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STK_W-1:0] STK_LAST = STK_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic sensor_s;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sensor_raw),
    .q     (sensor_s)
  );

  det_state_t       state_q, state_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [STK_W-1:0] stk_q, stk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             car_q, car_d;
  logic             fault_q, fault_d;
  logic             accept;
  logic [STK_W-1:0] stk_inc;

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    stk_d   = stk_q;
    accept  = 1'b0;
    // Presence counter saturates so a long RELEASING/PRESENT bounce cannot wrap past the stuck limit
    stk_inc = (stk_q == STK_LAST) ? stk_q : stk_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        stk_d = '0;
        if (sensor_s) begin
          state_d = ST_ARMING;
          deb_d   = '0;
        end
      end
      ST_ARMING: begin
        if (!sensor_s) begin
          state_d = ST_IDLE;
          stk_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = ST_PRESENT;
          stk_d   = '0;
          accept  = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      ST_PRESENT: begin
        stk_d = stk_inc;
        if (!sensor_s) begin
          state_d = ST_RELEASING;
          deb_d   = '0;
        end else if (stk_q == STK_LAST) begin
          state_d = ST_STUCK;
          deb_d   = '0;
        end
      end
      ST_RELEASING: begin
        stk_d = stk_inc;
        if (sensor_s) begin
          state_d = ST_PRESENT;
        end else if (deb_q == DEB_LAST) begin
          state_d = ST_IDLE;
          stk_d   = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      ST_STUCK: begin
        if (sensor_s) begin
          deb_d = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = ST_IDLE;
          stk_d   = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        deb_d   = '0;
        stk_d   = '0;
      end
    endcase

    // A fresh detection outranks a simultaneous green; a faulty loop drops any pending request
    if (accept) begin
      req_d = 1'b1;
    end else if (light_n_g) begin
      req_d = 1'b0;
    end else begin
      req_d = req_q;
    end
    if (state_d == ST_STUCK) begin
      req_d = 1'b0;
    end

    cnt_d   = (accept && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
    car_d   = (state_d != ST_STUCK) &&
              (req_d || (state_d == ST_PRESENT) || (state_d == ST_RELEASING));
    fault_d = (state_d == ST_STUCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      deb_q   <= '0;
      stk_q   <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      car_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      stk_q   <= stk_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      car_q   <= car_d;
      fault_q <= fault_d;
    end
  end

  assign car       = car_q;
  assign car_count = cnt_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_car_detector.sv
// tb/tb_car_detector.sv - directed bench for car_detector with a run-length behavioural model
module tb_car_detector;

  localparam int D = 4;
  localparam int S = 1024;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sensor_raw = 1'b0;
  logic         light_n_g = 1'b0;
  logic         car;
  logic [W-1:0] car_count;
  logic         fault;

  car_detector #(
    .DEBOUNCE_CYCLES (D),
    .STUCK_CYCLES    (S),
    .CNT_W           (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor_raw (sensor_raw),
    .light_n_g  (light_n_g),
    .car        (car),
    .car_count  (car_count),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: quiet / present / faulty, driven by run lengths of the synchronized sensor
  typedef struct {
    int s1, s2, mode, hi, lo, age, cnt;
    bit req;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t c, logic raw, logic light);
    model_t n = c;
    bit s = (c.s2 != 0);
    bit acc = 1'b0;
    n.s1 = int'(raw);
    n.s2 = c.s1;
    case (c.mode)
      0: begin
        if (s) begin
          n.hi = c.hi + 1;
          if (n.hi == D + 1) begin
            n.mode = 1; n.age = 0; n.lo = 0; acc = 1'b1;
          end
        end else begin
          n.hi = 0;
        end
      end
      1: begin
        if (s) begin
          if (c.lo == 0 && c.age >= S - 1) n.mode = 2;
          n.lo = 0;
        end else begin
          n.lo = c.lo + 1;
          if (n.lo == D + 1) begin n.mode = 0; n.hi = 0; end
        end
        n.age = c.age + 1;
      end
      default: begin
        if (!s) begin
          n.lo = c.lo + 1;
          if (n.lo == D) begin n.mode = 0; n.hi = 0; end
        end else begin
          n.lo = 0;
        end
      end
    endcase
    if (acc) begin
      n.req = 1'b1;
      if (c.cnt < (1 << W) - 1) n.cnt = c.cnt + 1;
    end else if (light) begin
      n.req = 1'b0;
    end
    if (n.mode == 2) n.req = 1'b0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else        m <= model_step(m, sensor_raw, light_n_g);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_car",   32'(car),       32'((m.mode != 2) && (m.req || m.mode == 1)));
      check("model_count", 32'(car_count), 32'(m.cnt));
      check("model_fault", 32'(fault),     32'(m.mode == 2));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    sensor_raw = 1'b0;
    light_n_g  = 1'b0;
    rst_n      = 1'b0;
    cyc(1);
    rst_n      = 1'b1;
  endtask

  initial begin
    int waited;
    cyc(2);
    check("reset_car", 32'(car), 0);
    check("reset_count", 32'(car_count), 0);
    check("reset_fault", 32'(fault), 0);
    rst_n = 1'b1;

    // Clean detection
    cyc(1);
    sensor_raw = 1'b1;
    cyc(6);
    check("clean_car_before_6", 32'(car), 0);
    cyc(1);
    check("clean_car_at_6", 32'(car), 1);
    check("clean_count", 32'(car_count), 1);
    cyc(13);
    sensor_raw = 1'b0;
    cyc(10);
    check("clean_car_held", 32'(car), 1);
    light_n_g = 1'b1;
    cyc(1);
    light_n_g = 1'b0;
    cyc(2);
    check("clean_car_served", 32'(car), 0);

    // Bounce rejection
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sensor_raw = 1'b1; cyc(3);
      sensor_raw = 1'b0; cyc(1);
    end
    cyc(4);
    check("bounce_car", 32'(car), 0);
    check("bounce_count", 32'(car_count), 0);
    sensor_raw = 1'b1;
    cyc(8);
    check("bounce_then_held_car", 32'(car), 1);
    check("bounce_then_held_count", 32'(car_count), 1);

    // Short dropout while present
    sensor_raw = 1'b0; cyc(2);
    sensor_raw = 1'b1; cyc(8);
    check("reentry_count", 32'(car_count), 1);
    check("reentry_car", 32'(car), 1);
    sensor_raw = 1'b0;
    light_n_g  = 1'b1;
    cyc(12);
    light_n_g  = 1'b0;
    check("reentry_cleared", 32'(car), 0);

    // Green on the very edge that accepts the vehicle
    do_reset();
    sensor_raw = 1'b1;
    cyc(6);
    light_n_g = 1'b1;
    cyc(1);
    light_n_g = 1'b0;
    check("simul_car", 32'(car), 1);
    sensor_raw = 1'b0;
    cyc(12);
    check("simul_req_survives", 32'(car), 1);
    light_n_g = 1'b1; cyc(1);
    light_n_g = 1'b0; cyc(1);
    check("simul_served", 32'(car), 0);

    // Stuck sensor
    do_reset();
    sensor_raw = 1'b1;
    waited = 0;
    while (!fault && waited < S + 50) begin
      cyc(1);
      waited++;
    end
    check("stuck_fault_seen", 32'(fault), 1);
    check("stuck_car_low", 32'(car), 0);
    check("stuck_entry_latency", 32'(waited), 32'(S + 6 + 1));
    if (waited < S + 10) cyc(S + 10 - waited);
    sensor_raw = 1'b0;
    cyc(8);
    check("stuck_fault_cleared", 32'(fault), 0);

    // Async reset with car=1 and car_count=7
    do_reset();
    for (int i = 0; i < 7; i++) begin
      sensor_raw = 1'b1; cyc(7);
      if (i < 6) begin sensor_raw = 1'b0; cyc(8); end
    end
    check("pre_reset_count", 32'(car_count), 7);
    check("pre_reset_car", 32'(car), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_car", 32'(car), 0);
    check("async_reset_count", 32'(car_count), 0);
    check("async_reset_fault", 32'(fault), 0);
    sensor_raw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Counter saturation
    for (int i = 0; i < 256; i++) begin
      sensor_raw = 1'b1; cyc(7);
      sensor_raw = 1'b0; cyc(8);
      if (i == 254) check("count_at_255", 32'(car_count), 255);
    end
    check("count_saturated", 32'(car_count), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
